// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU-to-peripheral bridge controller.
// Address layout: [31:6] selects the bridge, [5:4] picks the device window, [3:0] is the offset.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int unsigned WIN_BITS = 4;
  localparam int unsigned IDX_LSB  = 4;
  localparam int unsigned IDX_MSB  = 5;
  localparam int unsigned IDX_BITS = IDX_MSB - IDX_LSB + 1;

  localparam logic [31:0] DEFAULT_BASE = 32'h0000_7F00;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bridge_decode.sv
// Combinational address decode: bridge hit and device window index.
// BASE is expected to be 64-byte aligned; its low six bits are ignored.
module bridge_decode
  import bridge_pkg::*;
#(
  parameter int unsigned N_DEV = 3,
  parameter logic [31:0] BASE  = DEFAULT_BASE
) (
  input  logic [31:IDX_LSB]    addr,
  output logic                 hit,
  output logic [IDX_BITS-1:0]  idx
);

  logic base_match;
  logic idx_ok;

  assign idx        = addr[IDX_MSB:IDX_LSB];
  assign base_match = (addr[31:IDX_MSB+1] == BASE[31:IDX_MSB+1]);
  // Windows beyond N_DEV inside the bridge range are unpopulated and miss.
  assign idx_ok     = (32'(idx) < N_DEV);
  assign hit        = base_match && idx_ok;

endmodule

// File: rtl/bridge_ctrl.sv
// Bridge sequencing FSM: decodes a MEM-stage access, runs the ready/timeout handshake with one
// device, stalls the pipeline meanwhile and holds the read word on pr_rd for WB.
module bridge_ctrl
  import bridge_pkg::*;
#(
  parameter int unsigned N_DEV   = 3,
  parameter logic [31:0] BASE    = DEFAULT_BASE,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pr_req,
  input  logic                  pr_we,
  input  logic [31:0]           pr_addr,
  input  logic [31:0]           pr_wd,
  input  logic [3:0]            pr_be,
  output logic                  pr_stall,
  output logic [31:0]           pr_rd,
  output logic                  pr_err,
  output logic [7:0]            err_cnt,
  output logic [N_DEV-1:0]      dev_sel,
  output logic                  dev_we,
  output logic [WIN_BITS-1:0]   dev_addr,
  output logic [31:0]           dev_wd,
  output logic [3:0]            dev_be,
  input  logic [32*N_DEV-1:0]   dev_rd,
  input  logic [N_DEV-1:0]      dev_ready
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_t               state_q;
  logic [IDX_BITS-1:0]  idx_q;
  logic                 we_q;
  logic [WIN_BITS-1:0]  addr_q;
  logic [31:0]          wd_q;
  logic [7:0]           cnt_q;

  logic                 dec_hit;
  logic [IDX_BITS-1:0]  dec_idx;
  logic [N_DEV-1:0]     dec_sel;
  logic                 sel_ready;
  logic [31:0]          sel_rd;
  logic [7:0]           cnt_inc;

  bridge_decode #(
    .N_DEV (N_DEV),
    .BASE  (BASE)
  ) u_decode (
    .addr (pr_addr[31:IDX_LSB]),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  always_comb begin
    dec_sel = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      dec_sel[i] = (32'(dec_idx) == i);
    end
  end

  // Only the latched device's ready/data matter; other devices are ignored.
  assign sel_ready = dev_ready[idx_q];
  assign sel_rd    = dev_rd[{idx_q, 5'd0} +: 32];
  assign cnt_inc   = cnt_q + 8'd1;

  // Combinational so the stall asserts in the same cycle the request appears.
  always_comb begin
    pr_stall = ((state_q == IDLE) && pr_req) || (state_q == ACCESS);
  end

  assign dev_addr = addr_q;
  assign dev_wd   = wd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      pr_rd   <= '0;
      pr_err  <= 1'b0;
      err_cnt <= '0;
      dev_sel <= '0;
      dev_we  <= 1'b0;
      dev_be  <= '0;
    end else begin
      pr_err <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pr_req) begin
            if (dec_hit) begin
              idx_q   <= dec_idx;
              we_q    <= pr_we;
              addr_q  <= pr_addr[WIN_BITS-1:0];
              wd_q    <= pr_wd;
              cnt_q   <= '0;
              dev_sel <= dec_sel;
              dev_we  <= pr_we;
              dev_be  <= pr_be;
              state_q <= ACCESS;
            end else begin
              pr_rd   <= '0;
              pr_err  <= 1'b1;
              err_cnt <= sat_inc(err_cnt);
              state_q <= DONE;
            end
          end
        end
        ACCESS: begin
          // Ready wins over a timeout landing in the same cycle.
          if (sel_ready) begin
            if (!we_q) begin
              pr_rd <= sel_rd;
            end
            dev_sel <= '0;
            dev_we  <= 1'b0;
            dev_be  <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == TimeoutCnt) begin
              pr_rd   <= '0;
              pr_err  <= 1'b1;
              err_cnt <= sat_inc(err_cnt);
              dev_sel <= '0;
              dev_we  <= 1'b0;
              dev_be  <= '0;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // pr_req here still belongs to the completing instruction.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bridge_ctrl.md
# bridge_ctrl

Sequencing controller for the CPU-to-peripheral bridge. It accepts a load/store from the MEM stage whose address falls outside data memory, decodes it to one of `N_DEV` device windows, and runs a ready/timeout handshake with the selected device. While the access is in flight it stalls the pipeline. It then holds the captured read word on `pr_rd` so the WB stage can select it in place of `DMout`.

## Interface
Parameters:
- `N_DEV`, 3: number of device windows (1–4).
- `BASE`, 32'h0000_7F00: bridge base address; must be 64-byte aligned.
- `TIMEOUT`, 15: maximum ACCESS cycles without `dev_ready` before an error completion (1–255).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pr_req`  in  1  MEM stage holds a bridge access (address not in DM).
- `pr_we`  in  1  store (1) / load (0).
- `pr_addr`  in  32  byte address.
- `pr_wd`  in  32  store data.
- `pr_be`  in  4  byte enables.
- `pr_stall`  out  1  freeze the pipeline.
- `pr_rd`  out  32  registered read data, consumed by WB.
- `pr_err`  out  1  one-cycle pulse in DONE when the access missed or timed out.
- `err_cnt`  out  8  saturating count of error completions.
- `dev_sel`  out  N_DEV  one-hot device select.
- `dev_we`  out  1  write strobe to the selected device.
- `dev_addr`  out  4  byte offset within the window, `pr_addr[3:0]`.
- `dev_wd`  out  32  store data to the device.
- `dev_be`  out  4  byte enables to the device.
- `dev_rd`  in  32*N_DEV  read data; device i occupies bits `[32i+31:32i]`.
- `dev_ready`  in  N_DEV  device completes the access this cycle.

## Operation
Decode:
- Hit when `pr_addr[31:6] == BASE[31:6]` and `idx = pr_addr[5:4] < N_DEV`.
- Each device owns a 16-byte window.

FSM states are IDLE, ACCESS and DONE.
- **IDLE**
  - `pr_req` with a hit: latch `idx`, `pr_we`, `pr_addr[3:0]`, `pr_wd` and `pr_be`; clear the timeout counter; go to ACCESS.
  - `pr_req` with a miss: go to DONE with error, and load `pr_rd` with 0.
- **ACCESS**
  - `dev_sel[idx]=1`, and the `dev_*` outputs are driven from the latched values. `dev_we` equals the latched `pr_we`.
  - When `dev_ready[idx]=1`: for a load, `pr_rd <= dev_rd[idx]`; for a store, `pr_rd` is unchanged. Go to DONE.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT`, load `pr_rd` with 0 and go to DONE with error.
  - `dev_ready` bits of non-selected devices are ignored.
- **DONE**
  - `pr_stall=0` so that MEM advances.
  - `pr_err=1` if the access is flagged as an error; `err_cnt` increments and saturates at 255.
  - `pr_req` is ignored in this state, because it still belongs to the completing instruction.
  - Always returns to IDLE.

Other rules:
- `pr_stall` = (IDLE and `pr_req`) or ACCESS. This is combinational from `pr_req`, so the stall asserts in the request cycle.
- `pr_rd` holds its value until the next load completion or error. WB samples it one cycle after DONE.
- `dev_sel`, `dev_we` and `dev_be` are 0 outside ACCESS. `dev_wd` and `dev_addr` are don't-care outside ACCESS.

## Timing
- Reset values: state IDLE, `pr_rd`=0, `err_cnt`=0, counter 0, `pr_err`=0, `dev_sel`=0, `dev_we`=0, `dev_be`=0.
- An assertion of `rst` during ACCESS aborts the access immediately (asynchronously), and `dev_sel` drops.
- Device ready in the first ACCESS cycle gives 2 stall cycles:
  - IDLE request cycle.
  - ACCESS cycle.
  - DONE (no stall).
- A ready after k ACCESS cycles gives k+1 stall cycles.
- A timeout gives `TIMEOUT`+1 stall cycles.
- A miss gives 1 stall cycle (IDLE → DONE).
- A ready arriving in the same cycle the counter reaches `TIMEOUT` completes as success; ready has priority.
- Back-to-back bridge accesses restart in the IDLE cycle that follows DONE, so the minimum spacing is 3 cycles per access.
- The `err_cnt` saturation check is 8-bit unsigned; the value never wraps.

## Structure
- `bridge_pkg`:
  - `state_t` enum {IDLE, ACCESS, DONE}.
  - `WIN_BITS`=4 and the window-index field position `[5:4]`.
  - Default `BASE`.
- Sub-module `bridge_decode`: combinational `pr_addr` → {hit, idx}, parameterised by `N_DEV` and `BASE`.
- `bridge_ctrl` holds the FSM, the latches, the timeout counter and `err_cnt`.

## Test plan
- Load from 0x7F14, `dev_ready[1]` high in the first ACCESS cycle, `dev_rd[1]`=0x1234_5678:
  - `pr_stall` is high for exactly 2 cycles.
  - `pr_rd`=0x1234_5678 from DONE onward; `pr_err`=0.
- Store 0xCAFE_0001, be=4'b0011 to 0x7F08, ready delayed 4 cycles:
  - `dev_sel`=3'b001, `dev_we`=1, `dev_addr`=4'h8, `dev_be`=4'b0011 held for 5 ACCESS cycles.
  - 6 stall cycles; `pr_rd` is unchanged.
- Load from 0x7F24, `dev_ready[2]` never asserted, `TIMEOUT`=15:
  - 16 stall cycles, then `pr_err` pulses once.
  - `pr_rd`=0 and `err_cnt`=1.
- Load from 0x7F34 with `N_DEV`=3 (miss):
  - No `dev_sel` activity and 1 stall cycle.
  - `pr_err`=1 and `pr_rd`=0.
- Reset during the third ACCESS cycle:
  - `dev_sel` goes to 0 asynchronously and `pr_stall`=0.
  - After release, a new request completes normally.
- 256 consecutive misses: `err_cnt` stops at 255.
